// File: rtl/mips_mem_pkg.sv
// Shared encodings for the data-memory access path: access sizes, FSM states and the captured control bundle.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    READ    = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } state_t;

  typedef struct packed {
    logic       we;
    logic       sgn;
    logic [1:0] size;
  } req_ctl_t;

endpackage

// File: rtl/mem_access_check.sv
// Combinational request validation: size, range and (with MISALIGN_TRAP_EN) alignment; zero latency, no flow control.
// Without MISALIGN_TRAP_EN, misaligned half/word addresses are rounded down instead of trapped.
module mem_access_check
  import mips_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic [1:0]            size,
  input  logic [31:0]           addr,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] aligned_addr
);

  logic out_of_range;
  logic [ADDR_WIDTH-1:0] addr_lo;

  assign out_of_range = (addr >> ADDR_WIDTH) != 32'd0;
  assign addr_lo      = addr[ADDR_WIDTH-1:0];

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned   = ((size == SZ_HALF) && addr[0]) ||
                        ((size == SZ_WORD) && (addr[1:0] != 2'b00));
  assign err          = (size == SZ_RSVD) || out_of_range || misaligned;
  assign aligned_addr = addr_lo;
`else
  assign err          = (size == SZ_RSVD) || out_of_range;
  assign aligned_addr = {addr_lo[ADDR_WIDTH-1:2],
                         addr_lo[1] & (size != SZ_WORD),
                         addr_lo[0] & (size != SZ_HALF) & (size != SZ_WORD)};
`endif

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer for the dataRAM port; store 2, load DELAY+3, error 1 cycle(s) accept-to-response.
// One access in flight: req_ready only in IDLE. Optional MISALIGN_TRAP_EN traps misaligned half/word.
module mem_access_ctrl
  import mips_mem_pkg::*;
#(
  parameter int BIT_WIDTH  = 32,
  parameter int DELAY      = 0,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_signed,
  input  logic [1:0]            req_size,
  input  logic [31:0]           req_addr,
  input  logic [BIT_WIDTH-1:0]  req_wdata,
  output logic                  resp_valid,
  output logic [BIT_WIDTH-1:0]  resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [BIT_WIDTH-1:0]  mem_data,
  output logic                  mem_wren,
  output logic                  mem_isSigned,
  output logic [1:0]            mem_dataSize,
  input  logic [BIT_WIDTH-1:0]  mem_q
);

  localparam int CW = (DELAY > 0) ? $clog2(DELAY + 1) : 1;

  state_t                state;
  logic [CW-1:0]         cnt;
  req_ctl_t              ctl;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BIT_WIDTH-1:0]  wdata_q;
  logic                  err_q;
  logic                  chk_err;
  logic [ADDR_WIDTH-1:0] chk_addr;
  logic                  accept;

  mem_access_check #(.ADDR_WIDTH(ADDR_WIDTH)) u_check (
    .size         (req_size),
    .addr         (req_addr),
    .err          (chk_err),
    .aligned_addr (chk_addr)
  );

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      ctl        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ctl        <= '{we: req_we, sgn: req_signed, size: req_size};
            addr_q     <= chk_addr;
            wdata_q    <= req_wdata;
            err_q      <= chk_err;
            resp_rdata <= '0;
            cnt        <= CW'(DELAY);
            if (chk_err)     state <= RESP;
            else if (req_we) state <= WRITE;
            else             state <= READ;
          end
        end
        WRITE: state <= RESP;
        // Address stays registered for DELAY+1 cycles so the RAM output has settled before CAPTURE.
        READ: begin
          if (cnt == '0) state <= CAPTURE;
          else           cnt   <= cnt - CW'(1);
        end
        CAPTURE: begin
          resp_rdata <= mem_q;
          state      <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign resp_valid   = (state == RESP);
  assign resp_err     = err_q && (state == RESP);
  assign mem_wren     = (state == WRITE);
  assign mem_addr     = addr_q;
  assign mem_data     = wdata_q;
  assign mem_isSigned = ctl.sgn;
  assign mem_dataSize = ctl.size;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (DELAY=0 and DELAY=3) on behavioural dataRAM models,
// checked against a byte-array reference model of the memory and the accept-to-response latencies.
module tb_mem_access_ctrl;
  localparam int D0 = 0;
  localparam int D1 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v0, v1, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic        rdy0, rv0, re0, wren0, sg0, rdy1, rv1, re1, wren1, sg1;
  logic [31:0] rd0, md0, q0, rd1, md1, q1;
  logic [7:0]  ma0, ma1;
  logic [1:0]  ds0, ds1;

  int errors = 0;
  int checks = 0;

  bit [7:0]    ram0 [256];
  bit [7:0]    ram1 [256];
  bit [7:0]    exp_mem [256];
  logic [31:0] p0 [0:D0];
  logic [31:0] p1 [0:D1];

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  mem_access_ctrl #(.BIT_WIDTH(32), .DELAY(D0), .ADDR_WIDTH(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(rdy0), .req_we(req_we),
    .req_signed(req_signed), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv0), .resp_rdata(rd0), .resp_err(re0), .mem_addr(ma0), .mem_data(md0),
    .mem_wren(wren0), .mem_isSigned(sg0), .mem_dataSize(ds0), .mem_q(q0));

  mem_access_ctrl #(.BIT_WIDTH(32), .DELAY(D1), .ADDR_WIDTH(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rdy1), .req_we(req_we),
    .req_signed(req_signed), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_rdata(rd1), .resp_err(re1), .mem_addr(ma1), .mem_data(md1),
    .mem_wren(wren1), .mem_isSigned(sg1), .mem_dataSize(ds1), .mem_q(q1));

  function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] sz, input logic sg);
    case (sz)
      2'b00:   return sg ? {{24{w[7]}}, w[7:0]}   : {24'd0, w[7:0]};
      2'b01:   return sg ? {{16{w[15]}}, w[15:0]} : {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  // dataRAM models: registered read plus DELAY extra output stages, lane select done here
  always @(posedge clk) begin
    if (wren0) begin
      ram0[ma0] <= md0[7:0];
      if (ds0 != 2'b00) ram0[ma0 + 8'd1] <= md0[15:8];
      if (ds0 == 2'b10) begin ram0[ma0 + 8'd2] <= md0[23:16]; ram0[ma0 + 8'd3] <= md0[31:24]; end
    end
    p0[0] <= ext({ram0[ma0 + 8'd3], ram0[ma0 + 8'd2], ram0[ma0 + 8'd1], ram0[ma0]}, ds0, sg0);
    for (int i = 1; i <= D0; i++) p0[i] <= p0[i-1];
  end
  assign q0 = p0[D0];

  always @(posedge clk) begin
    if (wren1) begin
      ram1[ma1] <= md1[7:0];
      if (ds1 != 2'b00) ram1[ma1 + 8'd1] <= md1[15:8];
      if (ds1 == 2'b10) begin ram1[ma1 + 8'd2] <= md1[23:16]; ram1[ma1 + 8'd3] <= md1[31:24]; end
    end
    p1[0] <= ext({ram1[ma1 + 8'd3], ram1[ma1 + 8'd2], ram1[ma1 + 8'd1], ram1[ma1]}, ds1, sg1);
    for (int j = 1; j <= D1; j++) p1[j] <= p1[j-1];
  end
  assign q1 = p1[D1];

  task automatic scramble();
    req_we     = 1'($urandom);
    req_signed = 1'($urandom);
    req_size   = 2'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  // One transaction on the instances selected by mask; hold keeps DUT1's valid high until its response.
  task automatic txn(input logic [1:0] mask, input logic we, input logic sg, input logic [1:0] sz,
                     input logic [31:0] addr, input logic [31:0] wdata, input bit hold, input string name);
    logic        exp_err;
    logic [7:0]  a;
    logic [31:0] exp_rd;
    int          nb;
    int          exp_lat [2];
    int          lat [2];
    logic        err_s [2];
    logic [31:0] rd_s [2];
    int          wr_cnt [2];
    logic [7:0]  wr_addr [2];
    logic [31:0] wr_dat [2];
    logic [1:0]  wr_sz [2];
    logic [7:0]  addr1 [2];
    bit          moved [2];
    int          reaccept;
    bit          done;
    logic        s_rv [2], s_re [2], s_wren [2], s_rdy [2];
    logic [31:0] s_rd [2], s_md [2];
    logic [7:0]  s_ma [2];
    logic [1:0]  s_ds [2];

    nb      = (sz == 2'b11) ? 1 : (1 << sz);
    exp_err = (sz == 2'b11) || (addr > 32'd255) ||
              (TRAP && ((sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00)));
    a       = 8'(addr % 256);
    a       = 8'(a - (a % nb));
    exp_rd  = 32'd0;
    if (!exp_err && !we) begin
      for (int i = 0; i < nb; i++) exp_rd = exp_rd | (32'(exp_mem[8'(a + i)]) << (8 * i));
      if (sg && nb < 4 && exp_rd[8*nb-1]) exp_rd = exp_rd | (32'hFFFF_FFFF << (8 * nb));
    end
    exp_lat[0] = exp_err ? 1 : (we ? 2 : D0 + 3);
    exp_lat[1] = exp_err ? 1 : (we ? 2 : D1 + 3);
    for (int d = 0; d < 2; d++) begin
      lat[d] = 0; wr_cnt[d] = 0; moved[d] = 1'b0; addr1[d] = 8'd0;
      err_s[d] = 1'b0; rd_s[d] = 32'd0; wr_addr[d] = 8'd0; wr_dat[d] = 32'd0; wr_sz[d] = 2'd0;
    end
    reaccept = 0;

    @(negedge clk);
    req_we = we; req_signed = sg; req_size = sz; req_addr = addr; req_wdata = wdata;
    v0 = mask[0]; v1 = mask[1];
    s_rdy[0] = rdy0; s_rdy[1] = rdy1;
    for (int d = 0; d < 2; d++) if (mask[d]) begin
      checks++;
      if (s_rdy[d] !== 1'b1) begin errors++; $display("FAIL %s/dut%0d ready_idle: got %b want 1", name, d, s_rdy[d]); end
    end
    @(posedge clk);
    done = 1'b0;
    for (int idx = 1; idx <= 40 && !done; idx++) begin
      @(negedge clk);
      s_rv[0] = rv0; s_re[0] = re0; s_wren[0] = wren0; s_rdy[0] = rdy0; s_rd[0] = rd0; s_md[0] = md0; s_ma[0] = ma0; s_ds[0] = ds0;
      s_rv[1] = rv1; s_re[1] = re1; s_wren[1] = wren1; s_rdy[1] = rdy1; s_rd[1] = rd1; s_md[1] = md1; s_ma[1] = ma1; s_ds[1] = ds1;
      for (int d = 0; d < 2; d++) if (mask[d] && lat[d] == 0) begin
        if (idx == 1) addr1[d] = s_ma[d];
        else if (s_ma[d] !== addr1[d]) moved[d] = 1'b1;
        if (s_wren[d] === 1'b1) begin
          wr_cnt[d]++; wr_addr[d] = s_ma[d]; wr_dat[d] = s_md[d]; wr_sz[d] = s_ds[d];
        end
        if (s_rv[d] === 1'b1) begin lat[d] = idx; err_s[d] = s_re[d]; rd_s[d] = s_rd[d]; end
      end
      if (hold) begin
        if (v1 && s_rdy[1] === 1'b1) reaccept++;
        if (lat[1] != 0) v1 = 1'b0;
      end else if (idx == 1) begin
        v0 = 1'b0; v1 = 1'b0;
      end
      if (idx == 1) scramble();
      done = (!mask[0] || lat[0] != 0) && (!mask[1] || lat[1] != 0);
    end
    v0 = 1'b0; v1 = 1'b0;

    for (int d = 0; d < 2; d++) if (mask[d]) begin
      checks++;
      if (lat[d] != exp_lat[d]) begin errors++; $display("FAIL %s/dut%0d latency: got %0d want %0d (0 = timeout)", name, d, lat[d], exp_lat[d]); end
      checks++;
      if (err_s[d] !== exp_err) begin errors++; $display("FAIL %s/dut%0d resp_err: got %b want %b", name, d, err_s[d], exp_err); end
      checks++;
      if (rd_s[d] !== exp_rd) begin errors++; $display("FAIL %s/dut%0d resp_rdata: got %h want %h", name, d, rd_s[d], exp_rd); end
      checks++;
      if (wr_cnt[d] != ((we && !exp_err) ? 1 : 0)) begin
        errors++; $display("FAIL %s/dut%0d wren_cycles: got %0d want %0d", name, d, wr_cnt[d], (we && !exp_err) ? 1 : 0);
      end
      if (we && !exp_err) begin
        checks++;
        if (wr_addr[d] !== a || wr_dat[d] !== wdata || wr_sz[d] !== sz) begin
          errors++; $display("FAIL %s/dut%0d write_port: got a=%h d=%h s=%b want a=%h d=%h s=%b",
                             name, d, wr_addr[d], wr_dat[d], wr_sz[d], a, wdata, sz);
        end
      end
      if (!we && !exp_err) begin
        checks++;
        if (moved[d] || addr1[d] !== a) begin
          errors++; $display("FAIL %s/dut%0d read_addr_hold: got a=%h moved=%0d want a=%h moved=0", name, d, addr1[d], moved[d], a);
        end
      end
    end
    if (hold) begin
      checks++;
      if (reaccept != 0) begin errors++; $display("FAIL %s re_accept: got %0d want 0", name, reaccept); end
    end

    @(negedge clk);
    s_rv[0] = rv0; s_rv[1] = rv1; s_rdy[0] = rdy0; s_rdy[1] = rdy1;
    for (int d = 0; d < 2; d++) if (mask[d]) begin
      checks++;
      if (s_rv[d] !== 1'b0 || s_rdy[d] !== 1'b1) begin
        errors++; $display("FAIL %s/dut%0d after_resp: got valid=%b ready=%b want valid=0 ready=1", name, d, s_rv[d], s_rdy[d]);
      end
    end

    if (we && !exp_err)
      for (int i = 0; i < nb; i++) exp_mem[8'(a + i)] = 8'(wdata >> (8 * i));
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (rdy0 !== 1'b1 || rv0 !== 1'b0 || re0 !== 1'b0 || rd0 !== 32'd0 || wren0 !== 1'b0 ||
        ma0 !== 8'd0 || md0 !== 32'd0 || sg0 !== 1'b0 || ds0 !== 2'd0) begin
      errors++; $display("FAIL %s/dut0 reset_values: got rdy=%b v=%b e=%b rd=%h wr=%b a=%h d=%h s=%b sz=%b want 1 0 0 0 0 0 0 0 0",
                         name, rdy0, rv0, re0, rd0, wren0, ma0, md0, sg0, ds0);
    end
    checks++;
    if (rdy1 !== 1'b1 || rv1 !== 1'b0 || re1 !== 1'b0 || rd1 !== 32'd0 || wren1 !== 1'b0 ||
        ma1 !== 8'd0 || md1 !== 32'd0 || sg1 !== 1'b0 || ds1 !== 2'd0) begin
      errors++; $display("FAIL %s/dut1 reset_values: got rdy=%b v=%b e=%b rd=%h wr=%b a=%h d=%h s=%b sz=%b want 1 0 0 0 0 0 0 0 0",
                         name, rdy1, rv1, re1, rd1, wren1, ma1, md1, sg1, ds1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
  endtask

  task automatic test_store_word();
    txn(2'b11, 1'b1, 1'b0, 2'b10, 32'h10, 32'hDEAD_BEEF, 1'b0, "store_word");
    txn(2'b11, 1'b0, 1'b0, 2'b10, 32'h10, 32'h0, 1'b0, "load_word_back");
  endtask

  task automatic test_load_byte();
    txn(2'b11, 1'b1, 1'b0, 2'b00, 32'h13, 32'h0000_0080, 1'b0, "store_byte");
    txn(2'b11, 1'b0, 1'b1, 2'b00, 32'h13, 32'h0, 1'b0, "load_sbyte");
    txn(2'b11, 1'b0, 1'b0, 2'b00, 32'h13, 32'h0, 1'b0, "load_ubyte");
    txn(2'b11, 1'b0, 1'b1, 2'b01, 32'h12, 32'h0, 1'b0, "load_shalf");
  endtask

  task automatic test_delay_hold();
    txn(2'b10, 1'b0, 1'b0, 2'b10, 32'h10, 32'h0, 1'b1, "delay3_hold");
  endtask

  task automatic test_errors();
    txn(2'b11, 1'b1, 1'b0, 2'b10, 32'h0000_0100, 32'h1234_5678, 1'b0, "out_of_range");
    txn(2'b11, 1'b1, 1'b0, 2'b11, 32'h10, 32'h1234_5678, 1'b0, "size_rsvd");
    txn(2'b11, 1'b0, 1'b0, 2'b00, 32'h8000_0000, 32'h0, 1'b0, "oor_load");
    txn(2'b11, 1'b0, 1'b0, 2'b10, 32'h10, 32'h0, 1'b0, "no_write_after_err");
  endtask

  task automatic test_misalign();
    txn(2'b11, 1'b1, 1'b0, 2'b01, 32'h21, 32'h0000_A55A, 1'b0, "half_store_21");
    txn(2'b11, 1'b0, 1'b0, 2'b01, 32'h20, 32'h0, 1'b0, "half_load_20");
    txn(2'b11, 1'b0, 1'b1, 2'b10, 32'h13, 32'h0, 1'b0, "word_load_13");
  endtask

  task automatic test_reset_mid_access();
    int bad;
    bad = 0;
    @(negedge clk);
    req_we = 1'b0; req_signed = 1'b0; req_size = 2'b10; req_addr = 32'h10; v1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_mid");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rv1 !== 1'b0 || wren1 !== 1'b0 || rdy1 !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL reset_mid_quiet: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_random();
    logic [31:0] ad;
    logic [1:0]  sz;
    for (int n = 0; n < 40; n++) begin
      ad = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      txn(2'b11, 1'($urandom), 1'($urandom), sz, ad, $urandom, 1'b0, "random");
    end
  endtask

  initial begin
    v0 = 1'b0; v1 = 1'b0;
    scramble();
    test_reset();
    test_store_word();
    test_load_byte();
    test_delay_hold();
    test_errors();
    test_misalign();
    test_reset_mid_access();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
